// File: rtl/ro_pair_response_reader.sv
// RO-PUF measurement end: enables the RO bank, counts synchronized rising edges over a window,
// compares pairs and hands NUM_RO/2 response bits out on valid/ready. Option: RO_RESP_TIE_FLAG_EN.

module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic s1, s2, prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= ro;
            s2   <= s1;
            prev <= s2;
            if (clr)
                cnt <= '0;
            else if (en && s2 && !prev && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

module ro_pair_response_reader #(
    parameter int NUM_RO     = 4,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 8,
    parameter int WINDOW     = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pair_sel,
    input  logic [NUM_RO-1:0]   ro_in,
    output logic                ro_en,
    output logic                busy,
    output logic [NUM_RO/2-1:0] resp,
    output logic                resp_valid,
    input  logic                resp_ready
`ifdef RO_RESP_TIE_FLAG_EN
    ,
    output logic [NUM_RO/2-1:0] resp_tie
`endif
);
    localparam int NP   = NUM_RO / 2;
    localparam int TMAX = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SET_LAST = TW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, COUNT, COMPARE, HOLD} state_t;

    state_t                         state, state_nxt;
    logic [TW-1:0]                  timer;
    logic                           psel;
    logic                           cnt_clr, cnt_en;
    logic [NUM_RO-1:0][CNT_W-1:0]   cnt;
    logic [NP-1:0]                  resp_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (SETTLE_CYC == 0) ? COUNT : SETTLE;
            SETTLE:  if (timer == SET_LAST) state_nxt = COUNT;
            COUNT:   if (timer == WIN_LAST) state_nxt = COMPARE;
            COMPARE: state_nxt = HOLD;
            HOLD:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ro_en      = (state == SETTLE) || (state == COUNT);
        busy       = (state != IDLE);
        resp_valid = (state == HOLD);
        cnt_clr    = (state == IDLE) && start;
        cnt_en     = (state == COUNT);
    end

    // Timer restarts on every state change so each timed phase counts from zero.
    always_ff @(posedge clk) begin
        if (rst || state_nxt != state || !(state == SETTLE || state == COUNT))
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                         psel <= 1'b0;
        else if (state == IDLE && start) psel <= pair_sel;
    end

    for (genvar i = 0; i < NUM_RO; i++) begin : g_lane
        ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .ro  (ro_in[i]),
            .clr (cnt_clr),
            .en  (cnt_en),
            .cnt (cnt[i])
        );
    end

    // psel=0 pairs neighbours (2k,2k+1); psel=1 pairs halves (k,k+NP).
    always_comb begin
        resp_nxt = '0;
        for (int k = 0; k < NP; k++) begin
            if (psel) resp_nxt[k] = cnt[k] > cnt[k+NP];
            else      resp_nxt[k] = cnt[2*k] > cnt[2*k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                   resp <= '0;
        else if (state == COMPARE) resp <= resp_nxt;
    end

`ifdef RO_RESP_TIE_FLAG_EN
    logic [NP-1:0] tie_nxt;

    always_comb begin
        tie_nxt = '0;
        for (int k = 0; k < NP; k++) begin
            if (psel) tie_nxt[k] = cnt[k] == cnt[k+NP];
            else      tie_nxt[k] = cnt[2*k] == cnt[2*k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                   resp_tie <= '0;
        else if (state == COMPARE) resp_tie <= tie_nxt;
    end
`endif
endmodule

// File: tb/tb_ro_pair_response_reader.sv
// Bench: two configurations (16-bit/120-cycle and 4-bit/100-cycle) on shared stimulus,
// checked every cycle against an edge-history model plus literal expectations.

module tb_ro_pair_response_reader;
    localparam int S   = 8;
    localparam int WA  = 120;
    localparam int CWA = 16;
    localparam int WB  = 100;
    localparam int CWB = 4;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, pair_sel = 1'b0, resp_ready = 1'b1;
    logic [3:0] ro_in = 4'b0;
    logic       ro_en_a, busy_a, resp_valid_a, ro_en_b, busy_b, resp_valid_b;
    logic [1:0] resp_a, resp_b;
`ifdef RO_RESP_TIE_FLAG_EN
    logic [1:0] tie_a, tie_b;
`endif

    always #5 clk = ~clk;

    ro_pair_response_reader #(.NUM_RO(4), .CNT_W(CWA), .SETTLE_CYC(S), .WINDOW(WA)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pair_sel(pair_sel), .ro_in(ro_in),
        .ro_en(ro_en_a), .busy(busy_a), .resp(resp_a), .resp_valid(resp_valid_a),
        .resp_ready(resp_ready)
`ifdef RO_RESP_TIE_FLAG_EN
        , .resp_tie(tie_a)
`endif
    );

    ro_pair_response_reader #(.NUM_RO(4), .CNT_W(CWB), .SETTLE_CYC(S), .WINDOW(WB)) dut_b (
        .clk(clk), .rst(rst), .start(start), .pair_sel(pair_sel), .ro_in(ro_in),
        .ro_en(ro_en_b), .busy(busy_b), .resp(resp_b), .resp_valid(resp_valid_b),
        .resp_ready(resp_ready)
`ifdef RO_RESP_TIE_FLAG_EN
        , .resp_tie(tie_b)
`endif
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    bit [3:0] hist [0:32767];
    int per [4];
    int ph  [4];
    bit rand_ready = 1'b0;

    int       m_w  [2] = '{WA, WB};
    int       m_cw [2] = '{CWA, CWB};
    bit       m_act  [2];
    int       m_t0   [2];
    bit       m_psel [2];
    bit [1:0] m_resp [2];
    bit [1:0] m_tie  [2];

    logic [1:0] en_o, busy_o, vld_o;
    logic [1:0] resp_o [2];
    assign en_o   = {ro_en_b, ro_en_a};
    assign busy_o = {busy_b, busy_a};
    assign vld_o  = {resp_valid_b, resp_valid_a};
    assign resp_o[0] = resp_a;
    assign resp_o[1] = resp_b;
`ifdef RO_RESP_TIE_FLAG_EN
    logic [1:0] tie_o [2];
    assign tie_o[0] = tie_a;
    assign tie_o[1] = tie_b;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Rising edge counted at edge e when the twice-synchronized value (sampled at e-2) is 1
    // and the one before it (e-3) was 0; only edges strictly inside the window count.
    function automatic int count_edges(int i, int t0, int w, int cw);
        int n = 0;
        for (int e = t0 + S + 1; e <= t0 + S + w; e++)
            if (hist[e-2][i] && !hist[e-3][i]) n++;
        if (n > (1 << cw) - 1) n = (1 << cw) - 1;
        return n;
    endfunction

    always @(posedge clk) begin : model
        int e, d, a, b, ca, cb;
        bit [1:0] r, t;
        e = cyc + 1;
        cyc <= e;
        if (e < 32768) hist[e] <= ro_in;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k]  <= 1'b0;
                m_resp[k] <= 2'b0;
                m_tie[k]  <= 2'b0;
            end else if (!m_act[k]) begin
                if (start) begin
                    m_act[k]  <= 1'b1;
                    m_t0[k]   <= e;
                    m_psel[k] <= pair_sel;
                end
            end else begin
                d = e - 1 - m_t0[k];
                if (d == S + m_w[k]) begin
                    for (int p = 0; p < 2; p++) begin
                        a  = m_psel[k] ? p : 2*p;
                        b  = m_psel[k] ? p + 2 : 2*p + 1;
                        ca = count_edges(a, m_t0[k], m_w[k], m_cw[k]);
                        cb = count_edges(b, m_t0[k], m_w[k], m_cw[k]);
                        r[p] = ca > cb;
                        t[p] = ca == cb;
                    end
                    m_resp[k] <= r;
                    m_tie[k]  <= t;
                end else if (d >= S + m_w[k] + 1 && resp_ready) begin
                    m_act[k] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int d;
        if (cyc >= 1) begin
            for (int k = 0; k < 2; k++) begin
                d = cyc - m_t0[k];
                check(k == 0 ? "ro_en_a" : "ro_en_b", en_o[k], m_act[k] && d < S + m_w[k]);
                check(k == 0 ? "busy_a" : "busy_b", busy_o[k], m_act[k]);
                check(k == 0 ? "valid_a" : "valid_b", vld_o[k], m_act[k] && d >= S + m_w[k] + 1);
                check(k == 0 ? "resp_a" : "resp_b", resp_o[k], m_resp[k]);
`ifdef RO_RESP_TIE_FLAG_EN
                check(k == 0 ? "tie_a" : "tie_b", tie_o[k], m_tie[k]);
`endif
            end
        end
    end

    always @(negedge clk) begin : drive
        for (int i = 0; i < 4; i++) begin
            if (per[i] == 0) ro_in[i] = 1'($urandom);
            else             ro_in[i] = ((cyc + ph[i]) % per[i]) < (per[i] / 2);
        end
        if (rand_ready) resp_ready = 1'($urandom);
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy_a || busy_b) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic launch(input bit ps, output int sc);
        wait_idle();
        @(negedge clk);
        start = 1'b1; pair_sel = ps; sc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic measure(input bit ps, output int lat, output int en_cnt);
        int sc, n;
        launch(ps, sc);
        en_cnt = 0; n = 0;
        while (!resp_valid_a && n < 1000) begin
            if (ro_en_a) en_cnt++;
            @(negedge clk);
            n++;
        end
        if (!resp_valid_a) check("valid_timeout", 32'd1, 32'd0);
        lat = cyc - sc;
    endtask

    initial begin
        int lat, en, sc;
        logic [1:0] held;
        per = '{4, 6, 10, 5};
        ph  = '{0, 0, 0, 0};

        repeat (3) @(negedge clk);
        check("rst_ro_en", ro_en_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_valid", resp_valid_a, 0);
        check("rst_resp", resp_a, 0);
        rst = 1'b0;

        measure(1'b0, lat, en);
        check("lat_basic", lat, 130);
        check("ro_en_cycles", en, 128);
        check("resp_basic", resp_a, 2'b01);

        measure(1'b1, lat, en);
        check("resp_pair_sel1", resp_a, 2'b01);

        per[3] = 8;
        measure(1'b1, lat, en);
        check("resp_pair_p8", resp_a, 2'b11);

        per = '{2, 2, 2, 2};
        measure(1'b0, lat, en);
        check("resp_tie_a", resp_a, 2'b00);
        check("resp_sat_b", resp_b, 2'b00);
`ifdef RO_RESP_TIE_FLAG_EN
        check("tie_flag_a", tie_a, 2'b11);
        check("tie_flag_b", tie_b, 2'b11);
`endif

        // Backpressure with an ignored start pulse in HOLD.
        per = '{4, 6, 10, 5};
        wait_idle();
        resp_ready = 1'b0;
        measure(1'b0, lat, en);
        held = resp_a;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            check("bp_valid", resp_valid_a, 1);
            check("bp_resp", resp_a, held);
            @(negedge clk);
        end
        start = 1'b0;
        check("bp_resp_final", resp_a, 2'b01);
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_busy_after", busy_a, 0);
        check("bp_valid_after", resp_valid_a, 0);
        @(negedge clk);
        check("bp_start_ignored", busy_a, 0);

        // Abort in the middle of the counting window.
        launch(1'b0, sc);
        while (cyc < sc + 1 + S + 50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ro_en", ro_en_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_valid", resp_valid_a, 0);
        measure(1'b0, lat, en);
        check("after_abort_resp", resp_a, 2'b01);
        check("after_abort_lat", lat, 130);

        rand_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 4; i++) begin
                per[i] = $urandom_range(2, 12);
                ph[i]  = $urandom_range(0, 11);
            end
            if (t % 4 == 3) per[$urandom_range(0, 3)] = 0;
            measure(1'($urandom), lat, en);
            check("rand_lat", lat, 130);
            check("rand_en_cycles", en, 128);
        end
        rand_ready = 1'b0;
        resp_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ro_pair_response_reader.md
Name: ro_pair_response_reader

Overview:
- Measurement end of the cyclic RO-PUF. Drives the shared enable of NUM_RO ring oscillators and counts rising edges of each RO output over a fixed window of clk cycles.
- Compares the counts pairwise and emits NUM_RO/2 response bits to the challenge/response controller over a valid/ready handshake.
- Sits between the RO bank (ro1..ro4 instances) and the CRP collection logic.

Parameters:
- NUM_RO, 4, number of RO inputs; even, at least 2.
- CNT_W, 16, width of each edge counter.
- SETTLE_CYC, 8, clk cycles with ro_en high before counting starts.
- WINDOW, 1024, clk cycles of the counting window; must be at least 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a measurement.
- pair_sel  input  1  pairing select, sampled with start: 0 pairs (0,1),(2,3),…; 1 pairs (i, i+NUM_RO/2).
- ro_in  input  NUM_RO  raw RO outputs, asynchronous to clk.
- ro_en  output  1  enable to all ROs.
- busy  output  1  high whenever state is not IDLE.
- resp  output  NUM_RO/2  response bits, stable while resp_valid is high.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts the response.

Behaviour:
- Reset values: ro_en=0, busy=0, resp=0, resp_valid=0. All counters, synchronizers, the latched pair_sel and the timer clear to 0. FSM goes to IDLE. Reset mid-measurement aborts the measurement immediately; no response is produced.
- Input path: each ro_in bit passes through a 2-flop synchronizer and then an edge register. A rising edge is sync=1 while the previous value was 0.
- Counters:
  - Each counter increments by 1 per rising edge, only in COUNT.
  - Counters saturate at 2^CNT_W−1 and never wrap.
  - Counters clear on entry to SETTLE.
- FSM states: IDLE → SETTLE → COUNT → COMPARE → HOLD → IDLE.
  - IDLE: start=1 latches pair_sel and moves to SETTLE on the next cycle. start in any other state is ignored.
  - SETTLE: ro_en=1. Lasts exactly SETTLE_CYC cycles; SETTLE_CYC=0 skips directly to COUNT.
  - COUNT: ro_en=1. Lasts exactly WINDOW cycles.
  - COMPARE: ro_en=0, single cycle. For pair k with members (a,b): resp[k] = (cnt[a] > cnt[b]). A tie (equal counts) yields 0. resp is registered at the end of this cycle.
  - HOLD: resp_valid=1, resp held constant. The transfer occurs on a cycle with resp_valid and resp_ready both high; resp_valid drops the next cycle and the FSM returns to IDLE. resp keeps its last value afterwards.
- Latency: resp_valid first rises 1+SETTLE_CYC+WINDOW+1 cycles after the start cycle. With resp_ready held high, busy deasserts 1 cycle later.
- ro_en goes high the cycle after start is accepted and low the cycle after the last COUNT cycle.
- Edges that occur during SETTLE, or that are still in the synchronizer when COUNT exits, are not counted.

Optional Feature:
- Macro: RO_RESP_TIE_FLAG_EN.
- When defined:
  - Adds output resp_tie (NUM_RO/2 bits); bit k=1 when the pair-k counts were equal or both saturated.
  - resp_tie is registered with resp in COMPARE, held in HOLD, and resets to 0.
- When undefined: the port and its logic are absent; resp behaviour is identical.

Test Plan:
- Basic compare: NUM_RO=4, SETTLE_CYC=8, WINDOW=120, pair_sel=0. ro_in[0] period 4 clk, ro_in[1] period 6, ro_in[2] period 10, ro_in[3] period 5 → resp=2'b01. resp_valid rises exactly 130 cycles after start.
- Pairing: same stimulus with pair_sel=1 (pairs 0–2 and 1–3; counts about 30 vs 12 and 20 vs 24) → resp=2'b01. Rerun with ro_in[3] period 8 → resp=2'b11.
- Tie and saturation: CNT_W=4, WINDOW=100, all ro_in period 2 → both counters saturate at 15 → resp=2'b00; with RO_RESP_TIE_FLAG_EN defined, resp_tie=2'b11.
- Backpressure: hold resp_ready=0 for 20 cycles in HOLD → resp_valid and resp stable throughout. start pulsed during HOLD is ignored. Raise resp_ready → one transfer, then busy=0.
- Reset mid-COUNT: assert rst at cycle 50 of the window → the next cycle shows ro_en=0, busy=0, resp_valid=0. A fresh start then completes normally with correct resp.
- Enable timing: verify ro_en is high for exactly SETTLE_CYC+WINDOW=128 cycles per measurement and 0 in IDLE/COMPARE/HOLD. Verify no edge counts change outside COUNT.
